// File: rtl/pixel_stream_rx.sv
// pixel_stream_rx: receiving end of a registered pixel stream (sy, de, 8-bit RGB).
//   - Re-times the stream by one cycle and recovers the horizontal coordinate from de runs.
//   - Checks every line's length against H_RES and counts lines per frame.
//   - Accumulates a 32-bit per-frame checksum of {r,g,b}.
//   - Offers one result record per frame over a valid/ready handshake.
//
// Ports:
//   clk_pix        pixel clock, all logic on its rising edge
//   rst_pix        synchronous active-high reset
//   in_sy          vertical coordinate from the transmitter
//   in_de          data enable from the transmitter
//   in_r/g/b       pixel colour
//   rx_sx          recovered horizontal coordinate (aligned with rx_de)
//   rx_sy          in_sy delayed one cycle
//   rx_de          in_de delayed one cycle
//   rx_rgb         {in_r,in_g,in_b} delayed one cycle
//   res_valid      frame result available
//   res_ready      consumer accepts the result
//   res_sum        frame checksum (mod 2^32)
//   res_lines      lines seen in the frame (saturating)
//   res_bad_lines  lines whose length differed from H_RES (saturating)
//   res_short      frame ended before V_RES lines
//   res_overrun    a result was dropped since the last accepted one
module pixel_stream_rx #(
  parameter int unsigned CORDW = 10,
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] in_sy,
  input  logic             in_de,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  output logic [CORDW-1:0] rx_sx,
  output logic [CORDW-1:0] rx_sy,
  output logic             rx_de,
  output logic [23:0]      rx_rgb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_sum,
  output logic [CORDW-1:0] res_lines,
  output logic [CORDW-1:0] res_bad_lines,
  output logic             res_short,
  output logic             res_overrun
);

  localparam logic [0:0] StSeek    = 1'b0;
  localparam logic [0:0] StCapture = 1'b1;

  localparam logic [CORDW-1:0] LineLen  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] LastLine = CORDW'(V_RES - 1);

  // Re-timed stream; r_de doubles as the edge-detect history.
  logic [CORDW-1:0] r_sx;
  logic [CORDW-1:0] r_sy;
  logic             r_de;
  logic [23:0]      r_rgb;

  // Frame accumulators.
  logic [0:0]       r_state;
  logic [CORDW-1:0] r_pcnt;
  logic [31:0]      r_sum;
  logic [CORDW-1:0] r_lines;
  logic [CORDW-1:0] r_bad;

  // Result register.
  logic             r_res_valid;
  logic [31:0]      r_res_sum;
  logic [CORDW-1:0] r_res_lines;
  logic [CORDW-1:0] r_res_bad;
  logic             r_res_short;
  logic             r_res_overrun;
  logic             r_pending;

  logic [23:0]      w_rgb;
  logic             w_rise;
  logic             w_fall;
  logic             w_fs;
  logic [CORDW-1:0] w_lines_inc;
  logic [CORDW-1:0] w_bad_inc;

  logic [0:0]       w_state_d;
  logic [31:0]      w_sum_d;
  logic [CORDW-1:0] w_lines_d;
  logic [CORDW-1:0] w_bad_d;
  logic             w_done;
  logic [CORDW-1:0] w_rec_lines;
  logic [CORDW-1:0] w_rec_bad;
  logic             w_rec_short;

  assign w_rgb  = {in_r, in_g, in_b};
  assign w_rise = in_de & ~r_de;
  assign w_fall = ~in_de & r_de;
  assign w_fs   = w_rise & (in_sy == '0);

  // Saturating updates applied when a line ends.
  assign w_lines_inc = (&r_lines) ? r_lines : r_lines + 1'b1;
  assign w_bad_inc   = ((r_pcnt != LineLen) && !(&r_bad)) ? r_bad + 1'b1 : r_bad;

  always_comb begin
    w_state_d   = r_state;
    w_sum_d     = r_sum;
    w_lines_d   = r_lines;
    w_bad_d     = r_bad;
    w_done      = 1'b0;
    w_rec_lines = w_lines_inc;
    w_rec_bad   = w_bad_inc;
    w_rec_short = 1'b0;
    case (r_state)
      StSeek: begin
        if (w_fs) begin
          // The frame-start pixel itself is the first one counted.
          w_state_d = StCapture;
          w_sum_d   = {8'd0, w_rgb};
          w_lines_d = '0;
          w_bad_d   = '0;
        end
      end
      StCapture: begin
        if (w_fs) begin
          // Early restart: close the previous frame as short, open a new one now.
          w_done      = (r_lines != '0);
          w_rec_lines = r_lines;
          w_rec_bad   = r_bad;
          w_rec_short = 1'b1;
          w_sum_d     = {8'd0, w_rgb};
          w_lines_d   = '0;
          w_bad_d     = '0;
        end else begin
          if (in_de) begin
            w_sum_d = r_sum + {8'd0, w_rgb};
          end
          if (w_fall) begin
            w_lines_d = w_lines_inc;
            w_bad_d   = w_bad_inc;
            if (r_sy == LastLine) begin
              w_done    = 1'b1;
              w_state_d = StSeek;
            end
          end
        end
      end
      default: w_state_d = StSeek;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_de    <= 1'b0;
      r_rgb   <= '0;
      r_state <= StSeek;
      r_pcnt  <= '0;
      r_sum   <= '0;
      r_lines <= '0;
      r_bad   <= '0;
    end else begin
      r_sy    <= in_sy;
      r_de    <= in_de;
      r_rgb   <= w_rgb;
      r_state <= w_state_d;
      r_sum   <= w_sum_d;
      r_lines <= w_lines_d;
      r_bad   <= w_bad_d;
      if (w_rise) begin
        r_sx   <= '0;
        r_pcnt <= CORDW'(1);
      end else if (in_de) begin
        // in_de & r_de here: advance only while the re-timed de stays high.
        r_sx   <= r_sx + 1'b1;
        r_pcnt <= r_pcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_res_valid   <= 1'b0;
      r_res_sum     <= '0;
      r_res_lines   <= '0;
      r_res_bad     <= '0;
      r_res_short   <= 1'b0;
      r_res_overrun <= 1'b0;
      r_pending     <= 1'b0;
    end else if (w_done) begin
      if (!r_res_valid || res_ready) begin
        r_res_valid   <= 1'b1;
        r_res_sum     <= r_sum;
        r_res_lines   <= w_rec_lines;
        r_res_bad     <= w_rec_bad;
        r_res_short   <= w_rec_short;
        r_res_overrun <= r_pending;
        r_pending     <= 1'b0;
      end else begin
        // Consumer is stalled: keep the held record, remember the loss.
        r_pending <= 1'b1;
      end
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign rx_sx         = r_sx;
  assign rx_sy         = r_sy;
  assign rx_de         = r_de;
  assign rx_rgb        = r_rgb;
  assign res_valid     = r_res_valid;
  assign res_sum       = r_res_sum;
  assign res_lines     = r_res_lines;
  assign res_bad_lines = r_res_bad;
  assign res_short     = r_res_short;
  assign res_overrun   = r_res_overrun;

endmodule
